// File: rtl/multilane_serializer_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serializer_pkg : shared types and parameter helpers for multilane_serializer |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
package serializer_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  function automatic int calc_bpl(input int data_w, input int lanes);
    return data_w / lanes;
  endfunction

  function automatic bit params_ok(input int data_w, input int lanes, input int ce_div);
    return (lanes > 0) && ((data_w % lanes) == 0) && ((data_w / lanes) >= 2) && (ce_div >= 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/multilane_serializer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multilane_serializer_if : parallel word valid/ready handshake               |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
interface multilane_serializer_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] din;
  logic              din_valid;
  logic              din_ready;

  modport master (output din, output din_valid, input  din_ready);
  modport slave  (input  din, input  din_valid, output din_ready);
endinterface
`default_nettype wire

// File: rtl/multilane_serializer_ce_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ce_prescaler : one-cycle clock-enable tick every CE_DIV enabled clocks      |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module ce_prescaler #(
  parameter int CE_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic tick
);
  localparam int                 c_CNT_W = (CE_DIV > 1) ? $clog2(CE_DIV) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(CE_DIV - 1);

  logic [c_CNT_W-1:0] r_cnt;
  logic               w_wrap;

  assign w_wrap = (r_cnt == c_LAST);
  assign tick   = w_wrap && en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end
endmodule
`default_nettype wire

// File: rtl/multilane_serializer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | multilane_serializer : buffered word in, LANES-wide serial out with framing |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
module multilane_serializer
  import serializer_pkg::*;
#(
  parameter int               DATA_W    = 16,
  parameter int               LANES     = 2,
  parameter int               CE_DIV    = 4,
  parameter logic [LANES-1:0] IDLE_PAT  = {LANES{1'b0}},
  parameter bit               MSB_FIRST = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  multilane_serializer_if.slave   bus,
  output logic [LANES-1:0]        ser_out,
  output logic                    frame,
  output logic                    busy,
  output logic                    gap
);
  localparam int                 c_BPL      = calc_bpl(DATA_W, LANES);
  localparam int                 c_BIT_W    = (c_BPL > 1) ? $clog2(c_BPL) : 1;
  localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(c_BPL - 1);

  if (!params_ok(DATA_W, LANES, CE_DIV)) begin : g_param_check
    $error("multilane_serializer: illegal DATA_W/LANES/CE_DIV combination");
  end

  state_t              r_state;
  logic [DATA_W-1:0]   r_hold;
  logic                r_hold_valid;
  logic [DATA_W-1:0]   r_shift;
  logic [c_BIT_W-1:0]  r_bit_cnt;
  logic [LANES-1:0]    r_ser_out;
  logic                r_frame;
  logic                r_gap;

  logic                w_tick;
  logic                w_accept;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic [LANES-1:0]    w_head_load;
  logic [LANES-1:0]    w_head_shift;

  ce_prescaler #(.CE_DIV(CE_DIV)) u_ce_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .tick  (w_tick)
  );

  assign w_accept      = bus.din_valid && !r_hold_valid;
  assign bus.din_ready = !r_hold_valid;
  assign ser_out       = r_ser_out;
  assign frame         = r_frame;
  assign gap           = r_gap;
  assign busy          = (r_state == SHIFT) || r_hold_valid;

  // Each lane segment rotates so the next bit lands at the head; the head is
  // what gets registered onto the lane when the slot advances.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    localparam int c_LO = l * c_BPL;
    localparam int c_HI = c_LO + c_BPL - 1;
    if (MSB_FIRST) begin : g_msb
      assign w_shift_nxt[c_HI:c_LO] = {r_shift[c_HI-1:c_LO], r_shift[c_HI]};
      assign w_head_load[l]         = r_hold[c_HI];
      assign w_head_shift[l]        = r_shift[c_HI-1];
    end else begin : g_lsb
      assign w_shift_nxt[c_HI:c_LO] = {r_shift[c_LO], r_shift[c_HI:c_LO+1]};
      assign w_head_load[l]         = r_hold[c_LO];
      assign w_head_shift[l]        = r_shift[c_LO+1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= IDLE;
      r_hold       <= '0;
      r_hold_valid <= 1'b0;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_ser_out    <= IDLE_PAT;
      r_frame      <= 1'b0;
      r_gap        <= 1'b0;
    end else begin
      r_gap <= 1'b0;
      // Hold only empties on a tick, which requires hold_valid, so an accept
      // and a load can never land on the same edge.
      if (w_accept) begin
        r_hold       <= bus.din;
        r_hold_valid <= 1'b1;
      end
      if (w_tick) begin
        case (r_state)
          IDLE: begin
            if (r_hold_valid) begin
              r_shift      <= r_hold;
              r_ser_out    <= w_head_load;
              r_hold_valid <= 1'b0;
              r_bit_cnt    <= '0;
              r_frame      <= 1'b1;
              r_state      <= SHIFT;
            end else begin
              r_ser_out <= IDLE_PAT;
            end
          end
          SHIFT: begin
            if (r_bit_cnt != c_LAST_BIT) begin
              r_shift   <= w_shift_nxt;
              r_ser_out <= w_head_shift;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              r_frame   <= 1'b0;
            end else if (r_hold_valid) begin
              r_shift      <= r_hold;
              r_ser_out    <= w_head_load;
              r_hold_valid <= 1'b0;
              r_bit_cnt    <= '0;
              r_frame      <= 1'b1;
            end else begin
              r_ser_out <= IDLE_PAT;
              r_frame   <= 1'b0;
              r_gap     <= 1'b1;
              r_state   <= IDLE;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end
endmodule
`default_nettype wire

// File: doc/multilane_serializer.md
Name: multilane_serializer

Overview:
- Parametrised successor to the single-pair mux serializer.
- Accepts DATA_W-bit parallel words over a valid/ready handshake and buffers one word ahead.
- Shifts each word out on LANES serial lanes at a rate set by an internal clock-enable prescaler, with framing and gap indication.
- Sits between the PHY word source and the lane drivers in the TX path.

Parameters:
- DATA_W, 16, parallel word width; must be a multiple of LANES.
- LANES, 2, number of serial lanes.
- CE_DIV, 4, clk cycles per serial bit slot; legal range >=2.
- IDLE_PAT, {LANES{1'b0}}, per-lane level driven when no word is being shifted.
- MSB_FIRST, 1, bit order within a lane: 1 = MSB first, 0 = LSB first.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- en  in  1  serializer enable; 0 freezes the prescaler and shifting.
- din  in  DATA_W  parallel word.
- din_valid  in  1  din holds a valid word.
- din_ready  out  1  block can accept a word this cycle.
- ser_out  out  LANES  serial lane outputs, registered.
- frame  out  1  high during the first bit slot of each word.
- busy  out  1  a word is shifting or a word is buffered.
- gap  out  1  one-clk pulse when a word finishes and no word is buffered.

Behaviour:
- Derived constant: BPL = DATA_W/LANES, with BPL >= 2.
- Lane l carries din[(l+1)*BPL-1 : l*BPL].
- Reset (async assert, sync-safe deassert):
  - ser_out=IDLE_PAT, frame=0, busy=0, gap=0, din_ready=1.
  - Prescaler, bit counter, hold buffer and state all cleared.
- Prescaler:
  - cnt counts 0..CE_DIV-1 while en=1; tick is high when cnt==CE_DIV-1 && en.
  - en=0 holds cnt and all serializer state.
  - The handshake still operates while en=0.
- Hold buffer:
  - One entry; din_ready = !hold_valid.
  - A word is accepted on din_valid && din_ready and is captured into hold on that edge.
- FSM states: IDLE, SHIFT.
  - IDLE, on tick with hold_valid: load shift register from hold, clear hold_valid, bit_cnt=0, frame=1, go to SHIFT.
  - IDLE, on tick without hold_valid: ser_out=IDLE_PAT.
  - SHIFT, on tick with bit_cnt<BPL-1: shift one bit on every lane, bit_cnt++, frame=0.
  - SHIFT, on tick with bit_cnt==BPL-1 and hold_valid: load the next word seamlessly, frame=1, stay in SHIFT. There is no idle slot between words.
  - SHIFT, on tick with bit_cnt==BPL-1 and no hold_valid: ser_out=IDLE_PAT, gap pulses for 1 clk, go to IDLE.
- Timing and latency:
  - Outputs change only on the edge ending a tick cycle, so each bit is held for exactly CE_DIV clks.
  - Latency: word accepted at cycle t while IDLE, next tick at cycle k>t; the first bit appears at cycle k+1.
- Simultaneous events:
  - Accept and load in the same cycle cannot conflict: hold empties on a tick and refills at the earliest on the next edge.
  - Because CE_DIV>=2, back-to-back words sustain with no bubble.
- busy = (state==SHIFT) || hold_valid.
- Reset mid-word: outputs return to idle immediately; the in-flight word and buffered word are discarded.

Decomposition:
- Package serializer_pkg:
  - State enum {IDLE, SHIFT}.
  - Function computing BPL.
  - Localparam checks: DATA_W%LANES==0, CE_DIV>=2.
- Sub-module ce_prescaler: ports clk, rst_n, en, tick; parameter CE_DIV.
  - It replaces the fixed clock-enable block.
  - The serializer runs on clk and gates all updates with tick; it must not use a derived clock.

Test Plan:
- Reset: hold rst_n=0 with din_valid=1 -> ser_out=2'b00, frame=0, busy=0, gap=0, din_ready=1. No word is accepted until rst_n=1.
- Single word (DATA_W=16, LANES=2, CE_DIV=4), din=16'hA55A:
  - lane1 emits 1,0,1,0,0,1,0,1 and lane0 emits 0,1,0,1,1,0,1,0, each bit held 4 clk.
  - frame is high for the first 4 clk only; gap pulses once after slot 7; then ser_out=2'b00.
- Back-to-back: 16'hFF00 then 16'h00FF with din_valid held:
  - 16 contiguous slots; frame high in slots 0 and 8; gap only after slot 15.
- Backpressure: three words offered continuously -> din_ready=0 while hold is full, din held stable, all three serialized in order, none lost or duplicated.
- Enable freeze: en=0 for 10 clk after lane bit 3 of 16'hA55A -> ser_out frozen; resumes with bit 4, which is held a full 4 clk.
- Async reset mid-word (bit 5) with a second word buffered -> ser_out=IDLE_PAT in the same cycle, busy=0, din_ready=1; the buffered word is never emitted.
